// File: rtl/dcache_req_arbiter.sv
// ============================================================================
// Module  : dcache_req_arbiter
// Purpose : Round-robin sharing of one data-cache request port, with an
//           in-order ID FIFO that routes responses back to their requester.
// Revision: 1.0
// ============================================================================
`default_nettype none

module dcache_req_arbiter #(
    parameter int NUM_REQ         = 2,
    parameter int WORD_SIZE       = 32,
    parameter int ADDR_LENGTH     = 32,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_REQ-1:0]             s_req_valid,
    input  logic [NUM_REQ*ADDR_LENGTH-1:0] s_req_addr,
    input  logic [NUM_REQ*WORD_SIZE-1:0]   s_req_wdata,
    input  logic [NUM_REQ-1:0]             s_req_write,
    input  logic [NUM_REQ*3-1:0]           s_req_size,
    output logic [NUM_REQ-1:0]             s_req_ready,
    output logic [NUM_REQ-1:0]             s_resp_valid,
    output logic [WORD_SIZE-1:0]           s_resp_rdata,
    output logic                           m_req_valid,
    output logic [ADDR_LENGTH-1:0]         m_req_addr,
    output logic [WORD_SIZE-1:0]           m_req_wdata,
    output logic                           m_req_write,
    output logic [2:0]                     m_req_size,
    input  logic                           m_req_ready,
    input  logic                           m_resp_valid,
    input  logic [WORD_SIZE-1:0]           m_resp_rdata,
    output logic                           err_orphan_resp
);

    localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int PW  = $clog2(MAX_OUTSTANDING) + 1;
    localparam int AW  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    typedef enum logic [0:0] {
        ST_ARB  = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t          r_state;
    logic [IDW-1:0]  r_rr_ptr;
    logic [IDW-1:0]  r_hold_id;
    logic [IDW-1:0]  r_fifo [MAX_OUTSTANDING];
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic            r_orphan;

    logic [IDW-1:0]  w_grant;
    logic            w_sel;
    logic            w_full;
    logic            w_empty;
    logic            w_mvalid;
    logic            w_accept;
    logic            w_pop;
    logic [AW-1:0]   w_wr_idx;
    logic [AW-1:0]   w_rd_idx;
    logic [IDW-1:0]  w_head_id;

    // Lowest search offset from rr_ptr wins: iterate downward so it is written last.
    always_comb begin
        w_grant = '0;
        w_sel   = 1'b0;
        if (r_state == ST_HOLD) begin
            w_grant = r_hold_id;
            w_sel   = s_req_valid[r_hold_id];
        end else begin
            for (int k = NUM_REQ - 1; k >= 0; k--) begin
                if (s_req_valid[(int'(r_rr_ptr) + k) % NUM_REQ]) begin
                    w_grant = IDW'((int'(r_rr_ptr) + k) % NUM_REQ);
                    w_sel   = 1'b1;
                end
            end
        end
    end

    // Pointers carry a wrap bit; full when they differ only in that bit.
    assign w_full    = ((r_wr_ptr ^ r_rd_ptr) == PW'(MAX_OUTSTANDING));
    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_wr_idx  = AW'(r_wr_ptr % PW'(MAX_OUTSTANDING));
    assign w_rd_idx  = AW'(r_rd_ptr % PW'(MAX_OUTSTANDING));
    assign w_head_id = r_fifo[w_rd_idx];

    assign w_mvalid = rst_n && w_sel && !w_full;
    assign w_accept = w_mvalid && m_req_ready;
    assign w_pop    = rst_n && m_resp_valid && !w_empty;

    assign m_req_valid  = w_mvalid;
    assign s_req_ready  = w_accept ? (NUM_REQ'(1) << w_grant) : '0;
    assign s_resp_valid = w_pop ? (NUM_REQ'(1) << w_head_id) : '0;
    assign s_resp_rdata = m_resp_rdata;

    always_comb begin
        m_req_addr  = '0;
        m_req_wdata = '0;
        m_req_write = 1'b0;
        m_req_size  = '0;
        if (rst_n && w_sel) begin
            m_req_addr  = s_req_addr[w_grant*ADDR_LENGTH +: ADDR_LENGTH];
            m_req_wdata = s_req_wdata[w_grant*WORD_SIZE +: WORD_SIZE];
            m_req_write = s_req_write[w_grant];
            m_req_size  = s_req_size[w_grant*3 +: 3];
        end
    end

    assign err_orphan_resp = r_orphan;

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_fifo[w_wr_idx] <= w_grant;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_ARB;
            r_rr_ptr  <= '0;
            r_hold_id <= '0;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_orphan  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
                r_rr_ptr <= IDW'((int'(w_grant) + 1) % NUM_REQ);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (m_resp_valid && w_empty) begin
                r_orphan <= 1'b1;
            end
            case (r_state)
                ST_ARB: begin
                    if (w_mvalid && !m_req_ready) begin
                        r_hold_id <= w_grant;
                        r_state   <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    // Locked requester withdrew: release the lock without a push.
                    if (w_accept || !w_sel) begin
                        r_state <= ST_ARB;
                    end
                end
                default: r_state <= ST_ARB;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_dcache_req_arbiter.sv
// ============================================================================
// Module  : tb_dcache_req_arbiter
// Purpose : Directed self-checking bench for dcache_req_arbiter (2 req, depth 2).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_dcache_req_arbiter;

    localparam int NR = 2;
    localparam int WS = 32;
    localparam int AL = 32;

    logic              clk;
    logic              rst_n;
    logic [NR-1:0]     s_req_valid;
    logic [NR*AL-1:0]  s_req_addr;
    logic [NR*WS-1:0]  s_req_wdata;
    logic [NR-1:0]     s_req_write;
    logic [NR*3-1:0]   s_req_size;
    logic [NR-1:0]     s_req_ready;
    logic [NR-1:0]     s_resp_valid;
    logic [WS-1:0]     s_resp_rdata;
    logic              m_req_valid;
    logic [AL-1:0]     m_req_addr;
    logic [WS-1:0]     m_req_wdata;
    logic              m_req_write;
    logic [2:0]        m_req_size;
    logic              m_req_ready;
    logic              m_resp_valid;
    logic [WS-1:0]     m_resp_rdata;
    logic              err_orphan_resp;

    int checks = 0;
    int errors = 0;

    dcache_req_arbiter #(
        .NUM_REQ(NR), .WORD_SIZE(WS), .ADDR_LENGTH(AL), .MAX_OUTSTANDING(2)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .s_req_valid(s_req_valid), .s_req_addr(s_req_addr),
        .s_req_wdata(s_req_wdata), .s_req_write(s_req_write),
        .s_req_size(s_req_size), .s_req_ready(s_req_ready),
        .s_resp_valid(s_resp_valid), .s_resp_rdata(s_resp_rdata),
        .m_req_valid(m_req_valid), .m_req_addr(m_req_addr),
        .m_req_wdata(m_req_wdata), .m_req_write(m_req_write),
        .m_req_size(m_req_size), .m_req_ready(m_req_ready),
        .m_resp_valid(m_resp_valid), .m_resp_rdata(m_resp_rdata),
        .err_orphan_resp(err_orphan_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] v, input logic rdy, input logic rv, input logic [31:0] rd);
        s_req_valid  = v;
        m_req_ready  = rdy;
        m_resp_valid = rv;
        m_resp_rdata = rd;
        #1;
    endtask

    initial begin
        rst_n        = 1'b0;
        s_req_addr   = {32'h0000_1040, 32'h0000_1000};
        s_req_wdata  = {32'hD1D1_0001, 32'hD0D0_0000};
        s_req_write  = 2'b10;
        s_req_size   = {3'b001, 3'b010};
        // Reset holds every output low even with live inputs.
        s_req_valid  = 2'b11;
        m_req_ready  = 1'b1;
        m_resp_valid = 1'b1;
        m_resp_rdata = 32'h0;
        #12;
        chk("rst_s_req_ready",  s_req_ready, 2'b00);
        chk("rst_s_resp_valid", s_resp_valid, 2'b00);
        chk("rst_m_req_valid",  m_req_valid, 1'b0);
        chk("rst_err",          err_orphan_resp, 1'b0);
        drive(2'b00, 1'b0, 1'b0, 32'h0);
        tick();
        rst_n = 1'b1;
        tick();

        // Round-robin with back-to-back responses.
        drive(2'b11, 1'b1, 1'b0, 32'h0);
        chk("rr0_valid", m_req_valid, 1'b1);
        chk("rr0_addr",  m_req_addr, 32'h0000_1000);
        chk("rr0_ready", s_req_ready, 2'b01);
        chk("rr0_wdata", m_req_wdata, 32'hD0D0_0000);
        chk("rr0_size",  m_req_size, 3'b010);
        chk("rr0_write", m_req_write, 1'b0);
        tick();
        drive(2'b11, 1'b1, 1'b1, 32'hA5A5_0000);
        chk("rr1_addr",  m_req_addr, 32'h0000_1040);
        chk("rr1_ready", s_req_ready, 2'b10);
        chk("rr1_write", m_req_write, 1'b1);
        chk("rr1_size",  m_req_size, 3'b001);
        chk("rr1_wdata", m_req_wdata, 32'hD1D1_0001);
        chk("rsp0_valid", s_resp_valid, 2'b01);
        chk("rsp0_data",  s_resp_rdata, 32'hA5A5_0000);
        tick();
        drive(2'b11, 1'b1, 1'b1, 32'hA5A5_0001);
        chk("rr2_ready",  s_req_ready, 2'b01);
        chk("rsp1_valid", s_resp_valid, 2'b10);
        chk("rsp1_data",  s_resp_rdata, 32'hA5A5_0001);
        tick();
        drive(2'b11, 1'b1, 1'b1, 32'hA5A5_0002);
        chk("rr3_ready",  s_req_ready, 2'b10);
        chk("rsp2_valid", s_resp_valid, 2'b01);
        tick();
        drive(2'b00, 1'b1, 1'b1, 32'hA5A5_0003);
        chk("idle_valid", m_req_valid, 1'b0);
        chk("idle_addr",  m_req_addr, 32'h0);
        chk("rsp3_valid", s_resp_valid, 2'b10);
        tick();

        // Grant lock: req1 stalled, req0 arrives while locked.
        drive(2'b10, 1'b0, 1'b0, 32'h0);
        chk("lk0_addr",  m_req_addr, 32'h0000_1040);
        chk("lk0_valid", m_req_valid, 1'b1);
        chk("lk0_ready", s_req_ready, 2'b00);
        tick();
        drive(2'b11, 1'b0, 1'b0, 32'h0);
        chk("lk1_addr", m_req_addr, 32'h0000_1040);
        tick();
        drive(2'b11, 1'b0, 1'b0, 32'h0);
        chk("lk2_addr", m_req_addr, 32'h0000_1040);
        tick();
        drive(2'b11, 1'b1, 1'b0, 32'h0);
        chk("lk3_addr",  m_req_addr, 32'h0000_1040);
        chk("lk3_ready", s_req_ready, 2'b10);
        tick();
        drive(2'b01, 1'b1, 1'b0, 32'h0);
        chk("lk4_addr",  m_req_addr, 32'h0000_1000);
        chk("lk4_ready", s_req_ready, 2'b01);
        tick();

        // FIFO full (IDs 1,0 outstanding); a same-cycle pop must not free a slot.
        drive(2'b11, 1'b1, 1'b1, 32'hBEEF_0001);
        chk("full_valid", m_req_valid, 1'b0);
        chk("full_ready", s_req_ready, 2'b00);
        chk("full_rsp",   s_resp_valid, 2'b10);
        chk("full_data",  s_resp_rdata, 32'hBEEF_0001);
        tick();
        drive(2'b11, 1'b1, 1'b0, 32'h0);
        chk("after_full_ready", s_req_ready, 2'b10);
        chk("after_full_addr",  m_req_addr, 32'h0000_1040);
        tick();
        drive(2'b11, 1'b1, 1'b1, 32'hBEEF_0000);
        chk("full2_valid", m_req_valid, 1'b0);
        chk("full2_rsp",   s_resp_valid, 2'b01);
        tick();
        // One outstanding (ID1); lock req1's successor into HOLD.
        drive(2'b11, 1'b1, 1'b0, 32'h0);
        chk("pre_hold_ready", s_req_ready, 2'b01);
        tick();
        drive(2'b11, 1'b0, 1'b1, 32'hBEEF_0011);
        chk("full3_valid", m_req_valid, 1'b0);
        chk("full3_rsp",   s_resp_valid, 2'b10);
        tick();
        drive(2'b11, 1'b0, 1'b0, 32'h0);
        chk("hold_addr", m_req_addr, 32'h0000_1040);
        tick();
        drive(2'b11, 1'b0, 1'b0, 32'h0);
        chk("hold2_addr", m_req_addr, 32'h0000_1040);

        // Asynchronous reset mid-operation.
        #2;
        rst_n = 1'b0;
        m_req_ready = 1'b1;
        #1;
        chk("mid_rst_valid", m_req_valid, 1'b0);
        chk("mid_rst_ready", s_req_ready, 2'b00);
        chk("mid_rst_resp",  s_resp_valid, 2'b00);
        tick();
        rst_n = 1'b1;
        // Response for a flushed request is an orphan.
        drive(2'b00, 1'b1, 1'b1, 32'hDEAD_0000);
        chk("orph_resp",     s_resp_valid, 2'b00);
        chk("orph_err_pre",  err_orphan_resp, 1'b0);
        tick();
        drive(2'b11, 1'b1, 1'b0, 32'h0);
        chk("orph_err_set",  err_orphan_resp, 1'b1);
        chk("post_rst_addr", m_req_addr, 32'h0000_1000);
        chk("post_rst_ready", s_req_ready, 2'b01);
        tick();
        drive(2'b00, 1'b0, 1'b1, 32'hCAFE_0000);
        chk("post_rst_rsp",  s_resp_valid, 2'b01);
        tick();
        drive(2'b00, 1'b0, 1'b0, 32'h0);
        tick();
        chk("orph_err_hold", err_orphan_resp, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("orph_err_clr",  err_orphan_resp, 1'b0);
        tick();
        rst_n = 1'b1;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
